// File: rtl/axil_regfile_if.sv
// AXI4-lite bus bundle shared by the register-file slave and its bench.
// The master modport drives requests; the slave modport drives responses.
interface axil_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_regfile_slave.sv
// AXI4-lite slave exposing REG_COUNT byte-strobed registers, with independent
// AW/W capture, a one-hot write-commit pulse and all registers mirrored on reg_out.
module axil_regfile_slave #(
   parameter int                       DATA_WIDTH  = 32,
   parameter int                       ADDR_WIDTH  = 16,
   parameter int                       STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int                       REG_COUNT   = 8,
   parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   axil_regfile_if.slave                   s_axil,
   output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
   output logic [REG_COUNT-1:0]            reg_wr_pulse
);

   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
   localparam int SEL_W    = $clog2(REG_COUNT);
   localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(REG_COUNT);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HAVE_AW = 2'd1,
      HAVE_W  = 2'd2,
      RESP    = 2'd3
   } wr_state_e;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_VALID = 1'b1
   } rd_state_e;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_val,
      input logic [DATA_WIDTH-1:0] new_val,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_val;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_val[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_val[b*8 +: 8];
         end
      end
      return res;
   endfunction

   wr_state_e             wr_state_q, wr_state_d;
   rd_state_e             rd_state_q, rd_state_d;
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [REG_COUNT-1:0]  wr_pulse_q, wr_pulse_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
   logic [ADDR_WIDTH-1:0] wr_addr_s;
   logic [DATA_WIDTH-1:0] wr_data_s;
   logic [STRB_WIDTH-1:0] wr_strb_s;
   logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;
   logic                  wr_in_range_s, rd_in_range_s;
   logic [SEL_W-1:0]      wr_sel_s, rd_sel_s;
   logic                  unused_ok_s;

   assign aw_hs_s = s_axil.awvalid & awready_q;
   assign w_hs_s  = s_axil.wvalid & wready_q;
   assign ar_hs_s = s_axil.arvalid & arready_q;

   // A beat handshaking this cycle takes priority over the one held from earlier.
   assign wr_addr_s     = aw_hs_s ? s_axil.awaddr : awaddr_q;
   assign wr_data_s     = w_hs_s ? s_axil.wdata : wdata_q;
   assign wr_strb_s     = w_hs_s ? s_axil.wstrb : wstrb_q;
   assign wr_idx_s      = wr_addr_s[ADDR_WIDTH-1:ADDR_LSB];
   assign wr_in_range_s = ({1'b0, wr_idx_s} < REG_LIMIT);
   assign wr_sel_s      = wr_idx_s[SEL_W-1:0];
   assign rd_idx_s      = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign rd_in_range_s = ({1'b0, rd_idx_s} < REG_LIMIT);
   assign rd_sel_s      = rd_idx_s[SEL_W-1:0];

   assign unused_ok_s = ^{s_axil.awprot, s_axil.arprot,
                          wr_addr_s[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0]};

   // Write FSM next state, beat capture and register commit.
   always_comb begin
      wr_state_d = wr_state_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      commit_s   = 1'b0;

      case (wr_state_q)
         IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               wr_state_d = RESP;
               commit_s   = 1'b1;
            end else if (aw_hs_s) begin
               wr_state_d = HAVE_AW;
            end else if (w_hs_s) begin
               wr_state_d = HAVE_W;
            end else begin
               wr_state_d = IDLE;
            end
         end
         HAVE_AW: begin
            if (w_hs_s) begin
               wr_state_d = RESP;
               commit_s   = 1'b1;
            end else begin
               wr_state_d = HAVE_AW;
            end
         end
         HAVE_W: begin
            if (aw_hs_s) begin
               wr_state_d = RESP;
               commit_s   = 1'b1;
            end else begin
               wr_state_d = HAVE_W;
            end
         end
         RESP: begin
            if (s_axil.bready) begin
               wr_state_d = IDLE;
            end else begin
               wr_state_d = RESP;
            end
         end
         default: begin
            wr_state_d = IDLE;
         end
      endcase

      if (aw_hs_s) begin
         awaddr_d = s_axil.awaddr;
      end else begin
         awaddr_d = awaddr_q;
      end

      if (w_hs_s) begin
         wdata_d = s_axil.wdata;
         wstrb_d = s_axil.wstrb;
      end else begin
         wdata_d = wdata_q;
         wstrb_d = wstrb_q;
      end

      // A zero strobe still counts as a committed write and pulses.
      if (commit_s && wr_in_range_s) begin
         regs_d[wr_sel_s]     = merge_lanes(regs_q[wr_sel_s], wr_data_s, wr_strb_s);
         wr_pulse_d[wr_sel_s] = 1'b1;
         bresp_d              = RESP_OKAY;
      end else if (commit_s) begin
         bresp_d = RESP_SLVERR;
      end else begin
         bresp_d = bresp_q;
      end

      bvalid_d  = (wr_state_d == RESP);
      awready_d = (wr_state_d == IDLE) || (wr_state_d == HAVE_W);
      wready_d  = (wr_state_d == IDLE) || (wr_state_d == HAVE_AW);
   end

   // Read FSM next state; data is sampled from the pre-commit register array.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs_s && rd_in_range_s) begin
               rd_state_d = R_VALID;
               rdata_d    = regs_q[rd_sel_s];
               rresp_d    = RESP_OKAY;
            end else if (ar_hs_s) begin
               rd_state_d = R_VALID;
               rdata_d    = '0;
               rresp_d    = RESP_SLVERR;
            end else begin
               rd_state_d = R_IDLE;
            end
         end
         R_VALID: begin
            if (s_axil.rready) begin
               rd_state_d = R_IDLE;
            end else begin
               rd_state_d = R_VALID;
            end
         end
         default: begin
            rd_state_d = R_IDLE;
         end
      endcase

      arready_d = (rd_state_d == R_IDLE);
      rvalid_d  = (rd_state_d == R_VALID);
   end

   // State, register array and registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= IDLE;
         rd_state_q <= R_IDLE;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= RESET_VALUE;
         end
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b1;
         wready_q   <= 1'b1;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         wr_pulse_q <= '0;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rresp_q    <= 2'b00;
         rdata_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         regs_q     <= regs_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   // Flatten the register array onto reg_out.
   always_comb begin
      reg_out = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
      end
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = wready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.arready = arready_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;
   assign reg_wr_pulse   = wr_pulse_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Randomized self-checking bench for axil_regfile_slave against an array model
// of the register file; directed scenarios cover ordering, errors and reset.
module tb_axil_regfile_slave;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int RC = 8;

   logic             clk;
   logic             rst;
   logic [RC*DW-1:0] reg_out;
   logic [RC-1:0]    reg_wr_pulse;
   logic [DW-1:0]    model_regs [RC];
   int               n_checks;
   int               n_fail;

   axil_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axil_regfile_slave #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .RESET_VALUE(32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axil       (bus.slave),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < RC; i++) begin
         check_eq(tag, reg_out[i*DW +: DW], model_regs[i]);
      end
   endtask

   // Full write transaction: mode 0 = AW+W together, 1 = AW then W, 2 = W then AW.
   task automatic axil_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int mode, input int gap, input int bp);
      int            idx;
      logic [1:0]    exp_resp;
      logic [RC-1:0] exp_pulse;
      idx = int'(addr) / 4;
      if (idx < RC) begin
         exp_resp  = 2'b00;
         exp_pulse = RC'(1) << idx;
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
         end
      end else begin
         exp_resp  = 2'b10;
         exp_pulse = '0;
      end
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      if (mode == 0) begin
         check_eq("awready_idle", bus.awready, 1'b1);
         check_eq("wready_idle", bus.wready, 1'b1);
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
         @(negedge clk);
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
      end else if (mode == 1) begin
         bus.awvalid = 1'b1;
         @(negedge clk);
         bus.awvalid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            check_eq("b_early_aw", bus.bvalid, 1'b0);
            check_eq("awready_have_aw", bus.awready, 1'b0);
            @(negedge clk);
         end
         check_eq("wready_have_aw", bus.wready, 1'b1);
         bus.wvalid = 1'b1;
         @(negedge clk);
         bus.wvalid = 1'b0;
      end else begin
         bus.wvalid = 1'b1;
         @(negedge clk);
         bus.wvalid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            check_eq("b_early_w", bus.bvalid, 1'b0);
            check_eq("wready_have_w", bus.wready, 1'b0);
            @(negedge clk);
         end
         check_eq("awready_have_w", bus.awready, 1'b1);
         bus.awvalid = 1'b1;
         @(negedge clk);
         bus.awvalid = 1'b0;
      end
      check_eq("bvalid", bus.bvalid, 1'b1);
      check_eq("bresp", bus.bresp, exp_resp);
      check_eq("wr_pulse", reg_wr_pulse, exp_pulse);
      check_regs("reg_out_wr");
      for (int c = 0; c < bp; c++) begin
         @(negedge clk);
         check_eq("bvalid_hold", bus.bvalid, 1'b1);
         check_eq("bresp_hold", bus.bresp, exp_resp);
         check_eq("awready_resp", bus.awready, 1'b0);
         check_eq("wready_resp", bus.wready, 1'b0);
         check_eq("wr_pulse_once", reg_wr_pulse, {RC{1'b0}});
      end
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      check_eq("bvalid_done", bus.bvalid, 1'b0);
      check_eq("awready_back", bus.awready, 1'b1);
      check_eq("wready_back", bus.wready, 1'b1);
   endtask

   task automatic axil_read(input logic [AW-1:0] addr, input int bp);
      int         idx;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_resp;
      idx = int'(addr) / 4;
      exp_data = (idx < RC) ? model_regs[idx] : '0;
      exp_resp = (idx < RC) ? 2'b00 : 2'b10;
      check_eq("arready_idle", bus.arready, 1'b1);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      @(negedge clk);
      bus.arvalid = 1'b0;
      check_eq("rvalid", bus.rvalid, 1'b1);
      check_eq("rdata", bus.rdata, exp_data);
      check_eq("rresp", bus.rresp, exp_resp);
      for (int c = 0; c < bp; c++) begin
         @(negedge clk);
         check_eq("rvalid_hold", bus.rvalid, 1'b1);
         check_eq("rdata_hold", bus.rdata, exp_data);
         check_eq("rresp_hold", bus.rresp, exp_resp);
         check_eq("arready_busy", bus.arready, 1'b0);
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      check_eq("rvalid_done", bus.rvalid, 1'b0);
      check_eq("arready_back", bus.arready, 1'b1);
   endtask

   initial begin
      logic [DW-1:0] rnd_data;
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < RC; i++) model_regs[i] = '0;
      bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check_eq("rst_bvalid", bus.bvalid, 1'b0);
      check_eq("rst_rvalid", bus.rvalid, 1'b0);
      check_eq("rst_bresp", bus.bresp, 2'b00);
      check_eq("rst_rresp", bus.rresp, 2'b00);
      check_eq("rst_rdata", bus.rdata, 32'h0);
      check_eq("rst_pulse", reg_wr_pulse, {RC{1'b0}});
      check_eq("rst_awready", bus.awready, 1'b1);
      check_eq("rst_wready", bus.wready, 1'b1);
      check_eq("rst_arready", bus.arready, 1'b1);
      check_regs("rst_regs");

      // Same-cycle AW+W to register 1.
      axil_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      check_eq("aww_reg1", reg_out[63:32], 32'hDEADBEEF);

      // W three cycles ahead of AW with a partial strobe.
      axil_write(16'h0008, 32'h11223344, 4'hF, 0, 0, 0);
      axil_write(16'h0008, 32'hAABBCCDD, 4'h5, 2, 3, 0);
      check_eq("w_first_reg2", reg_out[95:64], 32'h11BB33DD);
      axil_write(16'h0008, 32'hFFFFFFFF, 4'h0, 1, 2, 0);
      check_eq("strb0_reg2", reg_out[95:64], 32'h11BB33DD);

      // Out-of-range write and read.
      axil_write(16'h0020, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      axil_read(16'h0020, 0);

      // Backpressure on both response channels.
      axil_write(16'h0010, 32'h0BADCAFE, 4'hF, 1, 1, 5);
      axil_read(16'h0010, 5);

      // AR handshake on the same edge as a write commit to reg3.
      axil_write(16'h000C, 32'h00000001, 4'hF, 0, 0, 0);
      bus.awaddr = 16'h000C; bus.wdata = 32'h00000002; bus.wstrb = 4'hF;
      bus.araddr = 16'h000C;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      model_regs[3] = 32'h00000002;
      check_eq("coll_rvalid", bus.rvalid, 1'b1);
      check_eq("coll_rdata", bus.rdata, 32'h00000001);
      check_eq("coll_bvalid", bus.bvalid, 1'b1);
      check_eq("coll_reg3", reg_out[127:96], 32'h00000002);
      bus.bready = 1'b1; bus.rready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0; bus.rready = 1'b0;
      check_eq("coll_bdone", bus.bvalid, 1'b0);
      check_eq("coll_rdone", bus.rvalid, 1'b0);

      // Random traffic; word indices 8..15 exercise the error path.
      for (int n = 0; n < 60; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         rnd_data = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            axil_write(a, rnd_data, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                       $urandom_range(0, 3), $urandom_range(0, 3));
         end else begin
            axil_read(a, $urandom_range(0, 3));
         end
      end

      // Reset after AW but before W abandons the write.
      bus.awaddr = 16'h0004; bus.awvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      check_eq("mid_awready", bus.awready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < RC; i++) model_regs[i] = '0;
      check_eq("mid_bvalid", bus.bvalid, 1'b0);
      check_eq("mid_awready_rst", bus.awready, 1'b1);
      check_eq("mid_wready_rst", bus.wready, 1'b1);
      check_eq("mid_arready_rst", bus.arready, 1'b1);
      check_regs("mid_regs");
      repeat (3) begin
         @(negedge clk);
         check_eq("mid_no_b", bus.bvalid, 1'b0);
      end
      axil_read(16'h0004, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_regfile_slave.md
AXIL_REGFILE_SLAVE -- requirements
Module: axil_regfile_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the AXI-lite data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the AXI-lite byte-address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, the byte-strobe width.
REQ-004 SHALL have parameter REG_COUNT, default 8, the register count; power of 2, range 2..256.
REQ-005 SHALL have parameter RESET_VALUE, default 0, the DATA_WIDTH value loaded into every register at reset.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-007 SHALL have AW ports: s_axil_awaddr in ADDR_WIDTH; s_axil_awprot in 3 (ignored); s_axil_awvalid in 1; s_axil_awready out 1.
REQ-008 SHALL have W ports: s_axil_wdata in DATA_WIDTH; s_axil_wstrb in STRB_WIDTH; s_axil_wvalid in 1; s_axil_wready out 1.
REQ-009 SHALL have B ports: s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-010 SHALL have AR ports: s_axil_araddr in ADDR_WIDTH; s_axil_arprot in 3 (ignored); s_axil_arvalid in 1; s_axil_arready out 1.
REQ-011 SHALL have R ports: s_axil_rdata out DATA_WIDTH; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.
REQ-012 SHALL have reg_out  out  REG_COUNT*DATA_WIDTH: all register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have reg_wr_pulse  out  REG_COUNT: one-hot, one-cycle pulse per committed write.

Function
REQ-014 SHALL decode word index = addr[ADDR_WIDTH-1 : log2(STRB_WIDTH)]; the access is in range iff index < REG_COUNT; low address bits are ignored.
REQ-015 SHALL implement the write path as an FSM with states IDLE, HAVE_AW, HAVE_W, RESP; in IDLE, awready=1 and wready=1.
REQ-016 SHALL capture AW and W independently, in either order or in the same cycle: an AW-only handshake moves IDLE->HAVE_AW, a W-only handshake moves IDLE->HAVE_W, and both together move IDLE->RESP.
REQ-017 SHALL drive awready=0 in HAVE_AW and RESP, and wready=0 in HAVE_W and RESP.
REQ-018 SHALL move HAVE_AW->RESP on the W handshake and HAVE_W->RESP on the AW handshake.
REQ-019 SHALL, on the clock edge that enters RESP with an in-range address: update only the byte lanes whose wstrb bit is 1, set bvalid=1 with bresp=2'b00, and pulse reg_wr_pulse[index] for that one cycle.
REQ-020 SHALL, on entering RESP with an out-of-range address: modify no register, assert no reg_wr_pulse bit, and set bresp=2'b10 (SLVERR).
REQ-021 SHALL, for a write with wstrb=0: commit no data change, still pulse reg_wr_pulse, and return OKAY.
REQ-022 SHALL hold bvalid and bresp stable in RESP until bready=1, then return to IDLE on that edge; a new AW/W is accepted no earlier than the following cycle.
REQ-023 SHALL implement the read path with states R_IDLE and R_VALID, driving arready=1 only in R_IDLE.
REQ-024 SHALL, on an AR handshake, register rdata and rresp and enter R_VALID on that edge (rvalid visible the next cycle); in-range reads return the register with OKAY, out-of-range reads return rdata=0 with SLVERR.
REQ-025 SHALL hold rdata, rresp and rvalid stable until rready=1, then return to R_IDLE.
REQ-026 SHALL run the read and write paths concurrently; when an AR handshake and a write commit to the same register occur on the same edge, the read SHALL return the pre-write value.
REQ-027 SHALL drive reg_out directly from the registers, so a write is visible on reg_out the cycle after its commit edge.
REQ-028 SHALL have no combinational path from any input valid/ready to any output ready/valid.

Reset
REQ-029 SHALL, while rst=1 on a clock edge: load every register to RESET_VALUE; force both FSMs to IDLE/R_IDLE; set bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0 and reg_wr_pulse=0.
REQ-030 SHALL discard any partially captured AW/W or pending B/R on reset mid-transaction, with no register write and no later response.
REQ-031 SHALL drive awready=wready=arready=1 in the first cycle after rst deasserts.

Verification
REQ-032 SHALL cover same-cycle AW+W: addr 0x0004, wdata 0xDEADBEEF, strb 0xF -> bvalid next cycle with OKAY, reg_wr_pulse=0x02, reg_out[63:32]=0xDEADBEEF.
REQ-033 SHALL cover W before AW with the handshakes 3 cycles apart and partial strobe: reg2=0x11223344, wdata 0xAABBCCDD, strb 0x5 -> reg2=0x11BB33DD; bvalid only after the AW handshake.
REQ-034 SHALL cover out of range: write to addr 0x0020 (REG_COUNT=8) -> SLVERR with no reg_out change; read of 0x0020 -> rdata=0, SLVERR.
REQ-035 SHALL cover backpressure: bready and rready held 0 for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stay stable and awready=wready=arready=0 throughout.
REQ-036 SHALL cover same-edge collision: read of reg3 (value 0x1) whose AR handshake coincides with a write commit of 0x2 to reg3 -> rdata=0x1, and reg_out shows 0x2 the next cycle.
REQ-037 SHALL cover reset mid-write: AW accepted, then rst=1 for one cycle before W -> no bvalid, all registers = RESET_VALUE, all readies = 1 after reset.
